// File: rtl/data_mem_mmio.sv
// data_mem_mmio: data-side word RAM plus memory-mapped output FIFO and cycle counter.
// Reads are combinational; all state updates on the rising edge of clk.
module data_mem_mmio #(
  parameter int RAM_WORDS = 256,
  parameter int FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        overflow
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0] count;
  logic [31:0] cycle, status;
  logic [15:0] off;
  logic mmio, full, pop, push, do_push, clr, cyc_wr;
  assign mmio = address_to_mem[31:16] == MMIO_BASE[31:16];
  assign off = address_to_mem[15:0];
  assign full = count == (PW+1)'(FIFO_DEPTH);
  assign pop = out_valid && out_ready;
  assign push = WE && mmio && off == 16'h0000;
  // a push into a full FIFO still lands if the head leaves in the same cycle
  assign do_push = push && (!full || pop);
  assign clr = WE && mmio && off == 16'h0004 && data_to_mem[10];
  assign cyc_wr = WE && mmio && off == 16'h0008;
  assign status = {21'd0, overflow, full, count == '0, 8'(count)};
  assign out_valid = count != '0;
  assign out_data = fifo[rptr];
  always_comb
    data_from_mem = !mmio ? ram[address_to_mem[AW+1:2]] :
                    off == 16'h0004 ? status :
                    off == 16'h0008 ? cycle : 32'd0;
  always_ff @(posedge clk) begin
    if (WE && !mmio) ram[address_to_mem[AW+1:2]] <= data_to_mem;
    if (do_push) fifo[wptr] <= data_to_mem;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      cycle <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(pop);
      overflow <= (push && full && !pop) || (overflow && !clr);
      cycle <= cyc_wr ? data_to_mem : cycle + 32'd1;
    end
endmodule
